// File: rtl/fb_pixel_writer_if.sv
// Bus bundles for the frame buffer writer: the incoming pixel stream and
// the Avalon-MM burst write master towards the HPS SDRAM port.
interface fb_pixel_if;
  logic [31:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;

  modport master (output pixel_data, output pixel_valid, input pixel_ready);
  modport slave  (input pixel_data, input pixel_valid, output pixel_ready);
endinterface

interface fb_avmm_if;
  logic [28:0] address;
  logic [7:0]  burstcount;
  logic [63:0] writedata;
  logic [7:0]  byteenable;
  logic        write;
  logic        waitrequest;

  modport master (output address, output burstcount, output writedata,
                  output byteenable, output write, input waitrequest);
  modport slave  (input address, input burstcount, input writedata,
                  input byteenable, input write, output waitrequest);
endinterface

// File: rtl/fb_pixel_writer.sv
// Packs 32-bit pixels two per 64-bit word into a FIFO and drains it into the
// SDRAM frame buffer with fixed-length Avalon write bursts.
//
// state   | meaning
// S_IDLE  | waiting for a full burst of words, or applying a pending restart
// S_BURST | issuing BURST_LENGTH back-to-back write beats at one address
module fb_pixel_writer #(
  parameter logic [29:0] ADDRESS      = 30'h3800_0000,
  parameter int          LENGTH_WORDS = 192000,
  parameter int          BURST_LENGTH = 16,
  parameter int          FIFO_DEPTH   = 32
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_frame_start,
  fb_pixel_if.slave  pix,
  fb_avmm_if.master  avm,
  output logic       o_frame_done,
  output logic       o_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [28:0]   BASE_WORD = {2'b00, ADDRESS[29:3]};
  localparam logic [29:0]   END_WORD  = {3'b000, ADDRESS[29:3]} + 30'(LENGTH_WORDS);
  localparam logic [CW-1:0] BL_C      = CW'(BURST_LENGTH);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [63:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_half;
  logic [31:0]   r_pack_low;
  logic          r_start_pending;
  logic [28:0]   r_next_addr;
  logic [28:0]   r_addr;
  logic          r_write;
  logic [7:0]    r_beat;
  logic          r_frame_done;

  logic          w_ready;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_last_beat;
  logic          w_flush;
  logic          w_start;
  logic [29:0]   w_next_sum;

  // Reset gates ready combinationally so no pixel is taken while in reset.
  assign w_ready     = !i_reset && !r_start_pending && (r_count < DEPTH_C);
  assign w_accept    = pix.pixel_valid && w_ready;
  assign w_push      = w_accept && r_half;
  assign w_pop       = r_write && !avm.waitrequest;
  assign w_last_beat = w_pop && (r_beat == 8'(BURST_LENGTH - 1));
  assign w_next_sum  = {1'b0, r_next_addr} + 30'(BURST_LENGTH);

  assign pix.pixel_ready = w_ready;
  assign avm.address     = r_addr;
  assign avm.burstcount  = 8'(BURST_LENGTH);
  assign avm.byteenable  = 8'hFF;
  assign avm.write       = r_write;
  assign avm.writedata   = r_mem[r_rd_ptr];
  assign o_frame_done    = r_frame_done;
  assign o_busy          = (r_state == S_BURST) || (r_count != '0) || r_half;

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_flush     = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_start_pending) begin
          w_flush = 1'b1;
        end else if (r_count >= BL_C) begin
          w_start     = 1'b1;
          w_state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if (w_last_beat) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr_ptr] <= {pix.pixel_data, r_pack_low};
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_half          <= 1'b0;
      r_pack_low      <= '0;
      r_start_pending <= 1'b0;
      r_next_addr     <= BASE_WORD;
      r_addr          <= BASE_WORD;
      r_write         <= 1'b0;
      r_beat          <= '0;
      r_frame_done    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      if (i_frame_start) r_start_pending <= 1'b1;
      else if (w_flush)  r_start_pending <= 1'b0;

      // Flush only happens in IDLE with ready low, so no push/pop can collide.
      if (w_flush) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_half      <= 1'b0;
        r_pack_low  <= '0;
        r_next_addr <= BASE_WORD;
      end else begin
        if (w_accept) begin
          r_half <= !r_half;
          if (!r_half) r_pack_low <= pix.pixel_data;
        end
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end

      if (w_start) begin
        r_write <= 1'b1;
        r_addr  <= r_next_addr;
        r_beat  <= '0;
      end else if (w_pop) begin
        r_beat <= r_beat + 8'd1;
        if (w_last_beat) begin
          r_write <= 1'b0;
          if (w_next_sum >= END_WORD) begin
            r_next_addr  <= BASE_WORD;
            r_frame_done <= 1'b1;
          end else begin
            r_next_addr <= w_next_sum[28:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench: two writers (full frame and a 32-word frame) share one
// stimulus and are checked against a word-queue model of the pixel stream.
module tb_fb_pixel_writer;

  localparam logic [28:0] BASE  = 29'h0700_0000;
  localparam int          LEN_A = 192000;
  localparam int          LEN_B = 32;
  localparam int          BL    = 16;

  logic        clk = 1'b0;
  logic        rst, fs, pvalid, wreq;
  logic [31:0] pdata;
  logic        fd_a, fd_b, busy_a, busy_b;

  always #10 clk = ~clk;

  fb_pixel_if pif_a ();
  fb_pixel_if pif_b ();
  fb_avmm_if  av_a ();
  fb_avmm_if  av_b ();

  assign pif_a.pixel_data  = pdata;
  assign pif_a.pixel_valid = pvalid;
  assign pif_b.pixel_data  = pdata;
  assign pif_b.pixel_valid = pvalid;
  assign av_a.waitrequest  = wreq;
  assign av_b.waitrequest  = wreq;

  fb_pixel_writer dut_a (
    .i_clock(clk), .i_reset(rst), .i_frame_start(fs),
    .pix(pif_a), .avm(av_a), .o_frame_done(fd_a), .o_busy(busy_a));

  fb_pixel_writer #(.LENGTH_WORDS(LEN_B)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_frame_start(fs),
    .pix(pif_b), .avm(av_b), .o_frame_done(fd_b), .o_busy(busy_b));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: words waiting to be written, burst index since restart.
  logic [63:0] m_q[$];
  bit          m_half;
  logic [31:0] m_low;
  int          m_k, m_beat, m_fwait;
  bit          m_pend, m_fd_a, m_fd_b, rst_prev, mon_acc;

  int          mon_pix, mon_beats, mon_wr, mon_stall, n_fd_a, n_fd_b;
  logic [28:0] baddr_a[$];
  logic [28:0] baddr_b[$];
  logic [63:0] bfirst[$];
  logic [63:0] cap_data[BL];

  function automatic logic [28:0] exp_addr(input int k, input int len);
    return BASE + 29'((k * BL) % len);
  endfunction

  always @(negedge clk) begin : monitor
    bit exp_rdy;
    mon_acc = 1'b0;
    if (rst) begin
      chk("ready_in_reset", {pif_a.pixel_ready, pif_b.pixel_ready}, 0);
      if (rst_prev) begin
        chk("write_in_reset", {av_a.write, av_b.write}, 0);
        chk("frame_done_in_reset", {fd_a, fd_b}, 0);
      end
      m_q.delete();
      m_half = 0; m_k = 0; m_beat = 0; m_fwait = 0; m_pend = 0;
      m_fd_a = 0; m_fd_b = 0;
    end else begin
      chk("frame_done_a", fd_a, m_fd_a);
      chk("frame_done_b", fd_b, m_fd_b);
      if (fd_a) n_fd_a++;
      if (fd_b) n_fd_b++;
      m_fd_a = 0; m_fd_b = 0;

      exp_rdy = !m_pend && (m_fwait == 0) && (m_q.size() < 32);
      chk("pixel_ready", {pif_a.pixel_ready, pif_b.pixel_ready}, {exp_rdy, exp_rdy});
      if (m_fwait > 0) m_fwait--;

      if (m_beat > 0)
        chk("write_continuous", {av_a.write, av_b.write}, 2'b11);
      else if (m_q.size() < BL)
        chk("no_partial_burst", {av_a.write, av_b.write}, 0);

      if (av_a.write) begin
        if (m_q.size() == 0) begin
          chk("write_without_data", av_a.write, 0);
        end else begin
          chk("writedata_a", av_a.writedata, m_q[0]);
          chk("writedata_b", av_b.writedata, m_q[0]);
          chk("address_a", av_a.address, exp_addr(m_k, LEN_A));
          chk("address_b", av_b.address, exp_addr(m_k, LEN_B));
          chk("burstcount", av_a.burstcount, BL);
          chk("byteenable", av_a.byteenable, 8'hFF);
          mon_wr++;
          if (wreq) begin
            mon_stall++;
          end else begin
            mon_acc = 1'b1;
            if (m_beat == 0) begin
              baddr_a.push_back(av_a.address);
              baddr_b.push_back(av_b.address);
              bfirst.push_back(av_a.writedata);
            end
            cap_data[m_beat] = av_a.writedata;
            void'(m_q.pop_front());
            m_beat++;
            mon_beats++;
            if (m_beat == BL) begin
              m_beat = 0;
              if (((m_k + 1) * BL) % LEN_A == 0) m_fd_a = 1;
              if (((m_k + 1) * BL) % LEN_B == 0) m_fd_b = 1;
              if (m_pend) begin
                m_pend = 0; m_fwait = 1; m_k = 0;
              end else begin
                m_k++;
              end
            end
          end
        end
      end

      if (pvalid && pif_a.pixel_ready) begin
        mon_pix++;
        if (m_half) begin
          m_q.push_back({pdata, m_low});
          m_half = 0;
        end else begin
          m_low = pdata;
          m_half = 1;
        end
      end

      // Restart: the burst in flight finishes, everything else is dropped.
      if (fs) begin
        m_half = 0;
        if (m_beat > 0) begin
          m_pend = 1;
          while (m_q.size() > BL - m_beat) void'(m_q.pop_back());
        end else begin
          m_fwait = 1; m_k = 0;
          m_q.delete();
        end
      end
    end
    rst_prev = rst;
  end

  // Avalon slave: 0 = constant, 1 = random stalls, 2 = stall beats 0 and 5.
  int wmode = 0;
  bit wconst = 0;
  int drv_beat, stall_left;
  bit armed = 1;

  always @(posedge clk) begin
    #2;
    if (rst) begin
      drv_beat = 0; armed = 1; stall_left = 0;
    end else if (mon_acc) begin
      drv_beat = (drv_beat + 1) % BL;
      armed = 1;
    end
    case (wmode)
      1: wreq = ($urandom_range(0, 3) == 0);
      2: begin
        if (av_a.write && armed && (drv_beat == 0 || drv_beat == 5)) begin
          stall_left = 3;
          armed = 0;
        end
        wreq = (stall_left > 0);
        if (stall_left > 0) stall_left--;
      end
      default: wreq = wconst;
    endcase
  end

  logic [31:0] pix_next;

  task automatic send_pixels(input int n, input bit rnd, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      bit done = 0;
      if (gaps) while ($urandom_range(0, 3) == 0) begin
        pvalid = 0;
        @(posedge clk); #1;
      end
      pdata  = rnd ? {8'h00, 24'($urandom)} : pix_next;
      pix_next++;
      pvalid = 1;
      while (!done) begin
        @(negedge clk);
        done = pif_a.pixel_ready;
        @(posedge clk); #1;
        t++;
        if (!done && t > 2000) begin
          chk("pixel_accept_timeout", pif_a.pixel_ready, 1);
          pvalid = 0;
          return;
        end
      end
    end
    pvalid = 0;
  endtask

  task automatic do_reset();
    rst = 1; fs = 0; pvalid = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    pix_next = 0;
  endtask

  task automatic clr_stats();
    mon_pix = 0; mon_beats = 0; mon_wr = 0; mon_stall = 0;
    n_fd_a = 0; n_fd_b = 0;
    baddr_a.delete(); baddr_b.delete(); bfirst.delete();
  endtask

  task automatic wait_beat(input int b);
    for (int t = 0; t < 200 && m_beat != b; t++) begin
      @(posedge clk); #1;
    end
    chk("reached_beat", m_beat, b);
  endtask

  typedef struct {
    int          beat;
    logic [63:0] data;
  } vec_t;
  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0,  64'h00000001_00000000};
    vecs[1] = '{1,  64'h00000003_00000002};
    vecs[2] = '{5,  64'h0000000B_0000000A};
    vecs[3] = '{6,  64'h0000000D_0000000C};
    vecs[4] = '{15, 64'h0000001F_0000001E};

    rst = 1; fs = 0; pvalid = 0; pdata = 0; pix_next = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_write", {av_a.write, av_b.write}, 0);
    chk("reset_busy", {busy_a, busy_b}, 0);
    rst = 0;
    @(negedge clk);
    chk("ready_after_reset", {pif_a.pixel_ready, pif_b.pixel_ready}, 2'b11);
    @(posedge clk); #1;

    // 1: one clean burst
    clr_stats();
    send_pixels(32, 0, 0);
    repeat (30) @(posedge clk); #1;
    chk("t1_bursts", baddr_a.size(), 1);
    chk("t1_addr", baddr_a[0], 29'h0700_0000);
    chk("t1_write_cycles", mon_wr, 16);
    for (int i = 0; i < 5; i++)
      chk($sformatf("t1_beat%0d", vecs[i].beat), cap_data[vecs[i].beat], vecs[i].data);

    // 2: stalls on beats 0 and 5
    do_reset(); clr_stats();
    wmode = 2;
    send_pixels(32, 0, 0);
    repeat (40) @(posedge clk); #1;
    wmode = 0;
    chk("t2_bursts", baddr_a.size(), 1);
    chk("t2_addr", baddr_a[0], 29'h0700_0000);
    chk("t2_beats", mon_beats, 16);
    chk("t2_stall_cycles", mon_stall, 6);
    for (int i = 0; i < 5; i++)
      chk($sformatf("t2_beat%0d", vecs[i].beat), cap_data[vecs[i].beat], vecs[i].data);

    // 3: FIFO fills while the slave stalls
    do_reset(); clr_stats();
    wconst = 1;
    send_pixels(64, 0, 0);
    pvalid = 1; pdata = pix_next;
    repeat (10) @(posedge clk); #1;
    chk("t3_pixels_accepted", mon_pix, 64);
    chk("t3_ready_low", pif_a.pixel_ready, 0);
    pvalid = 0; wconst = 0;
    repeat (60) @(posedge clk); #1;
    chk("t3_bursts", baddr_a.size(), 2);
    chk("t3_addr0", baddr_a[0], 29'h0700_0000);
    chk("t3_addr1", baddr_a[1], 29'h0700_0010);
    chk("t3_ready_back", pif_a.pixel_ready, 1);

    // 4: frame wrap on the 32-word instance, random data, gaps and stalls
    do_reset(); clr_stats();
    wmode = 1;
    send_pixels(96, 1, 1);
    repeat (150) @(posedge clk); #1;
    chk("t4_bursts", baddr_b.size(), 3);
    chk("t4_b_addr0", baddr_b[0], BASE);
    chk("t4_b_addr1", baddr_b[1], BASE + 29'd16);
    chk("t4_b_addr2", baddr_b[2], BASE);
    chk("t4_a_addr2", baddr_a[2], BASE + 29'd32);
    chk("t4_fd_b_pulses", n_fd_b, 1);
    chk("t4_fd_a_pulses", n_fd_a, 0);

    // random run: 100 words, 4 left over
    do_reset(); clr_stats();
    send_pixels(200, 1, 1);
    repeat (200) @(posedge clk); #1;
    wmode = 0;
    chk("rand_bursts", baddr_a.size(), 6);
    chk("rand_fd_b_pulses", n_fd_b, 3);
    chk("rand_busy", {busy_a, busy_b}, {2{(m_q.size() != 0) || m_half}});

    // 5: frame_start during beat 4 with 10 extra words and a half pixel
    do_reset(); clr_stats();
    wconst = 1;
    send_pixels(53, 0, 0);
    wconst = 0;
    wait_beat(4);
    wconst = 1; fs = 1;
    @(posedge clk); #1;
    fs = 0; wconst = 0;
    pix_next = 32'h0000_1000;
    send_pixels(32, 0, 0);
    repeat (60) @(posedge clk); #1;
    chk("t5_bursts", baddr_a.size(), 2);
    chk("t5_beats", mon_beats, 32);
    chk("t5_old_first", bfirst[0], 64'h00000001_00000000);
    chk("t5_new_addr", baddr_a[1], BASE);
    chk("t5_new_first", bfirst[1], 64'h00001001_00001000);
    chk("t5_fd_a", n_fd_a, 0);

    // 6: reset in the middle of a burst
    do_reset(); clr_stats();
    wconst = 1;
    send_pixels(32, 0, 0);
    wconst = 0;
    wait_beat(7);
    rst = 1;
    repeat (2) @(posedge clk); #1;
    chk("t6_write_after_reset", {av_a.write, av_b.write}, 0);
    rst = 0; pix_next = 0;
    chk("t6_busy", {busy_a, busy_b}, 0);
    clr_stats();
    send_pixels(32, 0, 0);
    repeat (40) @(posedge clk); #1;
    chk("t6_bursts", baddr_a.size(), 1);
    chk("t6_addr", baddr_a[0], 29'h0700_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Upstream producer for the frame buffer in SDRAM. Accepts a stream of 32-bit pixels, packs them two per 64-bit word and buffers the words in a FIFO.
- Writes the buffered words into the frame buffer region through the HPS f2h SDRAM Avalon-MM port, using fixed-length write bursts.
- Runs on the 50 MHz system clock, beside the display-side frame buffer reader, which reads the same memory region.

Parameters:
ADDRESS, 30'h3800_0000, frame buffer base byte address; must be 8-byte aligned.
LENGTH_WORDS, 192000, frame size in 64-bit words (800*480 pixels / 2); must be a multiple of BURST_LENGTH.
BURST_LENGTH, 16, beats per Avalon write burst; range 1..128.
FIFO_DEPTH, 32, word FIFO depth; must be at least BURST_LENGTH and a power of two.

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse: restart writing at the frame base
pixel_data  in  32  pixel, {8'h00, R, G, B}
pixel_valid  in  1  pixel_data valid
pixel_ready  out  1  block accepts pixel when pixel_valid && pixel_ready
address  out  29  Avalon word address (8-byte units)
burstcount  out  8  Avalon burst length
waitrequest  in  1  Avalon slave stall
writedata  out  64  Avalon write data
byteenable  out  8  Avalon byte enables
write  out  1  Avalon write request
frame_done  out  1  one-cycle pulse: last word of the frame accepted
busy  out  1  high in BURST, or while FIFO/pack register is non-empty

Behaviour:
- Reset is synchronous and active-high.
  - Values during and after reset: write=0, frame_done=0, pixel_ready=0 during reset and 1 on the first cycle after.
  - FIFO empty, pack register empty, next_address=ADDRESS>>3, state IDLE, pending start cleared.
  - Reset asserted mid-burst abandons the burst: write=0 on the cycle after reset is sampled.
- byteenable is constant 8'hFF. burstcount is constant BURST_LENGTH.
- Packing:
  - The 1st accepted pixel of a pair goes to pack_low. The 2nd forms word {pixel, pack_low} and is pushed into the FIFO in the same cycle.
  - The even pixel always occupies writedata[31:0].
- pixel_ready = !start_pending && (fifo_count < FIFO_DEPTH). A push and a pop in the same cycle are both honoured.
- State machine:
  - IDLE:
    - If start_pending: flush the FIFO, clear pack_low, set next_address=ADDRESS>>3, clear start_pending; stay in IDLE.
    - Else if fifo_count >= BURST_LENGTH: go to BURST, set write=1, address=next_address, beat=0.
    - Otherwise hold.
  - BURST:
    - write held at 1 for every beat, with no gaps. address stays constant for the whole burst. writedata = FIFO head.
    - While waitrequest=1, all outputs are held.
    - On each cycle with write && !waitrequest: pop the FIFO and increment beat.
    - On the accept of beat BURST_LENGTH-1: write=0 next cycle; next_address += BURST_LENGTH; return to IDLE (one bubble cycle between bursts).
- Wrap:
  - If next_address + BURST_LENGTH reaches (ADDRESS>>3) + LENGTH_WORDS, next_address wraps to ADDRESS>>3.
  - frame_done pulses high for exactly the cycle after that last beat is accepted.
- frame_start:
  - A pulse in any state sets start_pending.
  - If it arrives in BURST, the current burst completes normally; the flush is applied in the first IDLE cycle.
  - Buffered words and the half pixel are discarded at the flush; frame_done is not pulsed.
  - frame_start together with reset: reset wins.
- No partial bursts are ever issued. Words below the BURST_LENGTH threshold wait for more pixels or are discarded by frame_start.
- Latency: pixel 2*BURST_LENGTH accepted at cycle N gives write=1 at N+2 at the earliest.

Test Plan:
1. Reset, then stream pixels 0..31 with no stalls and waitrequest=0 -> exactly one burst.
   - Check: address=29'h0700_0000, burstcount=16, beat0 writedata=64'h00000001_00000000, beat15=64'h0000001F_0000001E.
   - Check: 16 contiguous write cycles.
2. Same stream with waitrequest=1 on beats 0 and 5 for 3 cycles each.
   - Check: address and writedata stable while stalled; exactly 16 beats accepted; data order unchanged.
3. Hold waitrequest=1 and push pixels continuously.
   - Check: pixel_ready drops after 64 accepted pixels (32 words).
   - Then release waitrequest -> two bursts at 0x0700_0000 and 0x0700_0010; pixel_ready reasserts.
4. With LENGTH_WORDS=32, stream 96 pixels.
   - Check: bursts at base, base+16, then base again.
   - Check: frame_done is a single-cycle pulse after burst 2's last beat only.
5. Assert frame_start during beat 4 of a burst, with 10 extra words queued and a half pixel pending.
   - Check: burst finishes all 16 beats; pixel_ready is low until the flush.
   - Check: the next 32 pixels produce a burst at base starting with the new pixels.
6. Assert reset at beat 7 of a burst.
   - Check: write=0 the next cycle, pixel_ready=0 during reset.
   - Check: after release, busy=0 and the next burst uses address 29'h0700_0000.
